asip_sequencer: RTL and testbench
=================================

# asip_sequencer

Multicycle control sequencer for the ASIP core. It replaces single-cycle control with an FSM that steps each instruction through fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a req/ack handshake. The instruction fields it decodes are `Tipo[1:0]` and `currentInstr[14:12]`, using the existing decoder encoding. It drives the datapath enables, muxes and ALU control, and enters a halted fault state on a memory timeout.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of wait cycles on any memory request before fault.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Tipo`  in  2  instruction class: 00 data, 01 memory, 10 branch, 11 illegal.
- `currentInstr`  in  3  bits [14:12] of the instruction register.
  - Data: [14] immediate, [13:12] op (00 ADD/MOV, 01 SUB, 10 CMP, 11 illegal).
  - Memory: [12] 1 = LDR, 0 = STR.
- `CondEx`  in  1  condition-pass from the condition unit, valid in DECODE.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `IRWrite`  out  1  load instruction register.
- `PCWrite`  out  1  load PC.
- `PCSrc`  out  1  PC source: 0 = PC+1, 1 = branch target.
- `RegW`  out  1  register file write.
- `MemtoReg`  out  1  writeback source: 1 = read data.
- `ALUSrc`  out  1  1 = immediate operand.
- `ALUControl`  out  2  00 add, 01 subtract.
- `FlagW`  out  2  flag write enables.
- `illegal`  out  1  one-cycle pulse when an illegal instruction is annulled.
- `fault`  out  1  sticky; set on memory timeout.
- `retired`  out  32  count of retired instructions (see Configuration).
- `cycles`  out  32  count of non-fault cycles since reset (see Configuration).

## Operation
- FSM states: FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, FAULT.
- **FETCH**
  - Drives `mem_req=1`, `AdrSrc=0`.
  - On the cycle `mem_ack=1`: pulses `IRWrite=1` and `PCWrite=1` with `PCSrc=0`, then goes to DECODE.
- **DECODE** (1 cycle, no side effects except `illegal`). Next state:
  - `Tipo=11` or data op 11 → `illegal` pulse, then FETCH.
  - `CondEx=0` → FETCH (annulled).
  - Data → EXEC.
  - Memory → MEMADR.
  - Branch → BRANCH.
- **EXEC**
  - `ALUSrc=currentInstr[14]`; `ALUControl` = 00 for op 00, 01 for ops 01/10.
  - CMP: `FlagW=2'b11`, then FETCH.
  - Otherwise: go to ALUWB.
- **ALUWB:** `RegW=1`, `MemtoReg=0`, then FETCH.
- **MEMADR:** `ALUSrc=1`, `ALUControl=00`. Next state: LDR → MEMRD, STR → MEMWR.
- **MEMRD:** `mem_req=1`, `AdrSrc=1`. On ack → MEMWB.
- **MEMWB:** `RegW=1`, `MemtoReg=1`, then FETCH.
- **MEMWR:** `mem_req=1`, `mem_we=1`, `AdrSrc=1`. On ack → FETCH.
- **BRANCH:** `ALUSrc=1`, `PCWrite=1`, `PCSrc=1`, then FETCH.
- **Retirement:** an instruction retires on its last cycle before FETCH. Annulled instructions (`CondEx=0`) count as retired; illegal instructions do not.
- **Memory timeout:**
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle `mem_req=1 && mem_ack=0`.
  - When the counter reaches `MEM_TIMEOUT` with no ack → FAULT.
  - In FAULT: `fault=1`, all outputs are inactive, and the block stays there until reset.
- All outputs not listed for a state are 0.

## Timing
- **Reset:** asynchronous, takes effect immediately while `reset=0`.
  - State = FETCH; all outputs 0 except `mem_req`, which rises to 1 in the first cycle after release.
  - Counters = 0, `fault=0`.
- `mem_ack` is sampled the same cycle as `mem_req`, so a zero-wait request completes in 1 cycle.
- `mem_req` and `mem_we` remain stable until the ack cycle. They deassert in the cycle after ack unless the next state also requests.
- **Latencies with zero-wait memory:**
  - ADD/SUB: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Annulled or illegal: 2 cycles.
  - Each memory wait cycle adds 1.
- **Timeout boundary:** an ack arriving in the same cycle the counter reaches `MEM_TIMEOUT` wins; the request completes normally.
- **Reset during a memory request:** `mem_req` drops asynchronously. Memory must tolerate an abandoned request.

## Configuration
- `ASIP_SEQ_PERF_EN` defined:
  - `retired` and `cycles` are live 32-bit counters.
  - They wrap from 0xFFFFFFFF to 0.
  - `cycles` freezes in FAULT.
- Not defined: `retired` and `cycles` are tied to 0, no counter flops are built, and the ports remain present.

## Test plan
- **Reset release, `mem_ack` held 1, instruction ADD immediate (`Tipo=00`, [14:12]=100), `CondEx=1`:** states FETCH, DECODE, EXEC, ALUWB; `RegW=1` in cycle 4; `retired=1` after cycle 4.
- **CMP ([14:12]=010):** `FlagW=11` in EXEC; `RegW` never asserted; next FETCH at cycle 4.
- **LDR with `mem_ack` delayed 3 cycles in MEMRD:** `mem_req` and `AdrSrc` held for 4 cycles; `RegW=1` with `MemtoReg=1` in MEMWB; total 8 cycles.
- **STR followed by branch with `CondEx=0`:** one `mem_we` pulse; branch annulled with `PCWrite` only from fetch; `retired=2`.
- **`Tipo=11`:** `illegal` pulses 1 cycle in DECODE; `retired` unchanged.
- **`mem_ack` held 0 in FETCH:** `fault=1` after 15 wait cycles; stays in FAULT; async reset mid-fault clears everything immediately.

Source files
------------

// File: rtl/asip_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a shared req/ack memory port.
// Define ASIP_SEQ_PERF_EN to build the retired-instruction and cycle counters.
module asip_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Tipo,
  input  logic [2:0]  currentInstr,
  input  logic        CondEx,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegW,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic [1:0]  FlagW,
  output logic        illegal,
  output logic        fault,
  output logic [31:0] retired,
  output logic [31:0] cycles
);

  // One spare count so the counter can step past MEM_TIMEOUT on the faulting cycle.
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StAluWb, StMemAdr,
    StMemRd, StMemWb, StMemWr, StBranch, StFault
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              req_q, req_d, we_q, we_d, adr_q, adr_d;
  logic              alusrc_q, alusrc_d, regw_q, regw_d, m2r_q, m2r_d;
  logic              br_q, br_d, fault_q, fault_d;
  logic [1:0]        aluctl_q, aluctl_d, flagw_q, flagw_d;
  logic [1:0]        op;
  logic              is_illegal, timed_out, fetch_ack;

  assign op         = currentInstr[1:0];
  assign is_illegal = (Tipo == 2'b11) || (Tipo == 2'b00 && op == 2'b11);
  assign timed_out  = (wait_q == CntW'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ack)        state_d = StDecode;
        else if (timed_out) state_d = StFault;
      end
      StDecode: begin
        if (is_illegal || !CondEx) state_d = StFetch;
        else if (Tipo == 2'b00)    state_d = StExec;
        else if (Tipo == 2'b01)    state_d = StMemAdr;
        else                       state_d = StBranch;
      end
      StExec:   state_d = (op == 2'b10) ? StFetch : StAluWb;
      StAluWb:  state_d = StFetch;
      StMemAdr: state_d = currentInstr[0] ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ack)        state_d = StMemWb;
        else if (timed_out) state_d = StFault;
      end
      StMemWb:  state_d = StFetch;
      StMemWr: begin
        if (mem_ack)        state_d = StFetch;
        else if (timed_out) state_d = StFault;
      end
      StBranch: state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StFetch;
    endcase
  end

  // Request states are only left on ack, so clearing on any non-waiting cycle covers entry.
  always_comb begin
    wait_d = (mem_req && !mem_ack) ? wait_q + CntW'(1) : '0;
  end

  // Moore outputs are decoded from the next state and registered.
  always_comb begin
    req_d    = state_d inside {StFetch, StMemRd, StMemWr};
    we_d     = (state_d == StMemWr);
    adr_d    = state_d inside {StMemRd, StMemWr};
    alusrc_d = (state_d == StExec) ? currentInstr[2] : (state_d inside {StMemAdr, StBranch});
    aluctl_d = (state_d == StExec && op != 2'b00) ? 2'b01 : 2'b00;
    flagw_d  = (state_d == StExec && op == 2'b10) ? 2'b11 : 2'b00;
    regw_d   = state_d inside {StAluWb, StMemWb};
    m2r_d    = (state_d == StMemWb);
    br_d     = (state_d == StBranch);
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      wait_q   <= '0;
      req_q    <= 1'b1;
      we_q     <= 1'b0;
      adr_q    <= 1'b0;
      alusrc_q <= 1'b0;
      aluctl_q <= 2'b00;
      flagw_q  <= 2'b00;
      regw_q   <= 1'b0;
      m2r_q    <= 1'b0;
      br_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      alusrc_q <= alusrc_d;
      aluctl_q <= aluctl_d;
      flagw_q  <= flagw_d;
      regw_q   <= regw_d;
      m2r_q    <= m2r_d;
      br_q     <= br_d;
      fault_q  <= fault_d;
    end
  end

  // req_q resets high for FETCH; gating with reset keeps the port quiet while reset is held.
  assign mem_req    = req_q & reset;
  assign fetch_ack  = mem_req && mem_ack && (state_q == StFetch);
  assign mem_we     = we_q;
  assign AdrSrc     = adr_q;
  assign IRWrite    = fetch_ack;
  assign PCWrite    = fetch_ack | br_q;
  assign PCSrc      = br_q;
  assign RegW       = regw_q;
  assign MemtoReg   = m2r_q;
  assign ALUSrc     = alusrc_q;
  assign ALUControl = aluctl_q;
  assign FlagW      = flagw_q;
  assign illegal    = (state_q == StDecode) && is_illegal;
  assign fault      = fault_q;

`ifdef ASIP_SEQ_PERF_EN
  logic [31:0] retired_q, cycles_q;
  logic        retire;

  assign retire = (state_q != StFetch) && (state_d == StFetch) && !illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      retired_q <= retired_q + 32'(retire);
      if (state_q != StFault) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`else
  assign retired = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_asip_sequencer.sv
// Randomized bench for asip_sequencer: each instruction is expanded into its expected
// per-cycle output sequence from the instruction class, condition and memory wait counts.
module tb_asip_sequencer;

`ifdef ASIP_SEQ_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Output vector layout: req we adr irw pcw pcs regw m2r alus aluc[2] flw[2] ill flt
  localparam logic [14:0] OReq  = 15'h4000;
  localparam logic [14:0] OWe   = 15'h2000;
  localparam logic [14:0] OAdr  = 15'h1000;
  localparam logic [14:0] OIrw  = 15'h0800;
  localparam logic [14:0] OPcw  = 15'h0400;
  localparam logic [14:0] OPcs  = 15'h0200;
  localparam logic [14:0] ORegw = 15'h0100;
  localparam logic [14:0] OM2r  = 15'h0080;
  localparam logic [14:0] OAlus = 15'h0040;
  localparam logic [14:0] OSub  = 15'h0010;
  localparam logic [14:0] OFlw  = 15'h000C;
  localparam logic [14:0] OIll  = 15'h0002;
  localparam logic [14:0] OFlt  = 15'h0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Tipo = 2'b00;
  logic [2:0]  currentInstr = 3'b000;
  logic        CondEx = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc, RegW, MemtoReg, ALUSrc;
  logic [1:0]  ALUControl, FlagW;
  logic        illegal, fault;
  logic [31:0] retired, cycles;
  logic [14:0] outs;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned retired_exp = 0;
  int unsigned cycles_exp = 0;
  logic [15:0] exp_q[$];   // {mem_ack to drive, expected outputs}

  asip_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Tipo(Tipo), .currentInstr(currentInstr), .CondEx(CondEx),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegW(RegW), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .FlagW(FlagW), .illegal(illegal),
    .fault(fault), .retired(retired), .cycles(cycles)
  );

  assign outs = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCSrc, RegW, MemtoReg, ALUSrc,
                 ALUControl, FlagW, illegal, fault};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int unsigned v);
    return PerfEn ? v : 32'd0;
  endfunction

  function automatic logic rnd_ack();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_req(input logic [14:0] o, input int waits, input logic [14:0] ack_extra);
    for (int w = 0; w < waits; w++) exp_q.push_back({1'b0, o});
    exp_q.push_back({1'b1, o | ack_extra});
  endtask

  task automatic check_counters(input string name);
    check({name, " retired"}, retired, cnt_exp(retired_exp));
    check({name, " cycles"}, cycles, cnt_exp(cycles_exp));
  endtask

  // fw/mw: wait cycles before ack on the fetch and on the data access.
  task automatic run_instr(input logic [1:0] tipo, input logic [2:0] ir, input logic cex,
                           input int fw, input int mw, input string name);
    logic        ill;
    logic [14:0] alu;
    exp_q.delete();
    push_req(OReq, fw, OIrw | OPcw);
    ill = (tipo == 2'b11) || (tipo == 2'b00 && ir[1:0] == 2'b11);
    exp_q.push_back({rnd_ack(), ill ? OIll : 15'h0});
    if (!ill && cex) begin
      case (tipo)
        2'b00: begin
          alu = (ir[2] ? OAlus : 15'h0) | ((ir[1:0] != 2'b00) ? OSub : 15'h0);
          if (ir[1:0] == 2'b10) begin
            exp_q.push_back({rnd_ack(), alu | OFlw});
          end else begin
            exp_q.push_back({rnd_ack(), alu});
            exp_q.push_back({rnd_ack(), ORegw});
          end
        end
        2'b01: begin
          exp_q.push_back({rnd_ack(), OAlus});
          if (ir[0]) begin
            push_req(OReq | OAdr, mw, 15'h0);
            exp_q.push_back({rnd_ack(), ORegw | OM2r});
          end else begin
            push_req(OReq | OWe | OAdr, mw, 15'h0);
          end
        end
        default: exp_q.push_back({rnd_ack(), OAlus | OPcw | OPcs});
      endcase
    end
    Tipo = tipo;
    currentInstr = ir;
    CondEx = cex;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ack = exp_q[i][15];
      @(negedge clk);
      check($sformatf("%s cyc%0d outs", name, i + 1), {17'b0, outs}, {17'b0, exp_q[i][14:0]});
      cycles_exp++;
      @(posedge clk);
      #1;
    end
    if (!ill) retired_exp++;
    check_counters(name);
  endtask

  task automatic hold_reset(input string name);
    reset = 1'b0;
    mem_ack = 1'b1;
    retired_exp = 0;
    cycles_exp = 0;
    #1;
    check({name, " outs in reset"}, {17'b0, outs}, 32'd0);
    check_counters(name);
    @(posedge clk);
    #1;
    check({name, " outs held"}, {17'b0, outs}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    hold_reset("por");

    run_instr(2'b00, 3'b100, 1'b1, 0, 0, "add_imm");
    run_instr(2'b00, 3'b010, 1'b1, 0, 0, "cmp");
    run_instr(2'b01, 3'b001, 1'b1, 0, 3, "ldr_w3");
    run_instr(2'b01, 3'b000, 1'b1, 0, 0, "str");
    run_instr(2'b10, 3'b000, 1'b0, 0, 0, "br_annul");
    run_instr(2'b11, 3'b101, 1'b1, 0, 0, "tipo11");
    run_instr(2'b00, 3'b011, 1'b1, 1, 0, "dataop11");
    run_instr(2'b00, 3'b001, 1'b1, 2, 0, "sub_reg");
    run_instr(2'b10, 3'b000, 1'b1, 0, 0, "br_taken");
    run_instr(2'b00, 3'b000, 1'b1, 15, 0, "fetch_w15");
    run_instr(2'b01, 3'b001, 1'b1, 0, 15, "ldr_w15");
    run_instr(2'b01, 3'b000, 1'b1, 1, 15, "str_w15");

    for (int n = 0; n < 60; n++) begin
      run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 4),
                $sformatf("rnd%0d", n));
    end

    // Fetch never acked: 15 wait cycles, the decision cycle, then sticky FAULT.
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("to_wait%0d outs", i + 1), {17'b0, outs}, {17'b0, OReq});
      cycles_exp++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      mem_ack = rnd_ack();
      @(negedge clk);
      check($sformatf("fault%0d outs", i), {17'b0, outs}, {17'b0, OFlt});
      check_counters($sformatf("fault%0d", i));
      @(posedge clk);
      #1;
    end
    #2;
    hold_reset("fault_rst");

    run_instr(2'b00, 3'b001, 1'b1, 0, 0, "post_sub");
    run_instr(2'b01, 3'b001, 1'b1, 2, 1, "post_ldr");

    // Abandoned fetch: mem_req must drop as soon as reset asserts.
    mem_ack = 1'b0;
    @(negedge clk);
    check("abandon outs", {17'b0, outs}, {17'b0, OReq});
    #2;
    reset = 1'b0;
    #1;
    check("abandon mem_req", {31'b0, mem_req}, 32'd0);
    check("abandon retired", retired, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
